pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_skid_buf.sv | 38 +++
 rtl/pipe_stage_reg.sv | 166 ++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register and its skid entry.
// This package provides the controller state encoding, the default payload
// geometry and the NOP word. A NOP is an all-zero field, and an empty stage
// presents NOPs downstream.
package pipe_pkg;

  localparam int DEFAULT_DATA_W     = 32;
  localparam int DEFAULT_NUM_FIELDS = 6;

  // All-zero word, decoded downstream as an architectural NOP.
  localparam logic [DEFAULT_DATA_W-1:0] NOP_WORD = '0;

  // States of the skid-enabled handshake controller.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry skid buffer for pipe_stage_reg.
// While the output register is back-pressured, this entry holds the payload
// that was accepted in the same cycle. Whether the entry is occupied is
// tracked by the owning controller. Here we only hold the data and return it
// to NOP when it is drained or flushed.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int NUM_FIELDS = DEFAULT_NUM_FIELDS
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load,
  input  logic                         clear,
  input  logic [NUM_FIELDS*DATA_W-1:0] load_data,
  output logic [NUM_FIELDS*DATA_W-1:0] data
);

  localparam int                 PAY_W       = NUM_FIELDS * DATA_W;
  localparam logic [PAY_W-1:0]   NOP_PAYLOAD = {NUM_FIELDS{DATA_W'(NOP_WORD)}};

  logic [PAY_W-1:0] data_reg;

  // Capture on load; clear (flush or drain) wins so no stale payload lingers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_reg <= NOP_PAYLOAD;
    end else if (clear) begin
      data_reg <= NOP_PAYLOAD;
    end else if (load) begin
      data_reg <= load_data;
    end
  end

  assign data = data_reg;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a valid/ready handshake, flush and a
// saturating stall counter.
// Build option: when PIPE_STAGE_SKID_EN is defined, a one-entry skid buffer
// is added and in_ready comes straight from a register. In the default build
// there is a single register, and in_ready is a combinational function of
// out_ready.
// Reset is synchronous and active-low. It overrides flush and any transfer.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int NUM_FIELDS = DEFAULT_NUM_FIELDS,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_FIELDS*DATA_W-1:0] in_data,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_FIELDS*DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]             stall_cnt
);

  localparam int               PAY_W       = NUM_FIELDS * DATA_W;
  localparam logic [PAY_W-1:0] NOP_PAYLOAD = {NUM_FIELDS{DATA_W'(NOP_WORD)}};

  logic             out_valid_int;
  logic [PAY_W-1:0] out_data_reg;
  logic [PAY_W-1:0] load_data;
  logic             load_out;
  logic             clear_out;
  logic [CNT_W-1:0] stall_cnt_reg;

`ifdef PIPE_STAGE_SKID_EN
  pipe_state_t      state_reg;
  pipe_state_t      state_next;
  logic             from_skid;
  logic             skid_load;
  logic             skid_clear;
  logic [PAY_W-1:0] skid_data;

  // Controller next state and datapath strobes; flush empties everything.
  always_comb begin
    state_next = state_reg;
    load_out   = 1'b0;
    clear_out  = 1'b0;
    from_skid  = 1'b0;
    skid_load  = 1'b0;
    if (flush) begin
      state_next = EMPTY;
      clear_out  = 1'b1;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (in_valid) begin
            state_next = FULL;
            load_out   = 1'b1;
          end
        end
        FULL: begin
          if (in_valid && !out_ready) begin
            state_next = SKID;
            skid_load  = 1'b1;
          end else if (in_valid && out_ready) begin
            load_out = 1'b1;
          end else if (out_ready) begin
            state_next = EMPTY;
            clear_out  = 1'b1;
          end
        end
        SKID: begin
          if (out_ready) begin
            state_next = FULL;
            load_out   = 1'b1;
            from_skid  = 1'b1;
          end
        end
        default: begin
          state_next = EMPTY;
          clear_out  = 1'b1;
        end
      endcase
    end
  end

  // Controller state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  assign skid_clear = flush || from_skid;

  pipe_skid_buf #(
    .DATA_W     (DATA_W),
    .NUM_FIELDS (NUM_FIELDS)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .load      (skid_load),
    .clear     (skid_clear),
    .load_data (in_data),
    .data      (skid_data)
  );

  // Per-field source select for the output register: skid entry or upstream.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
      assign load_data[gi*DATA_W +: DATA_W] =
        from_skid ? skid_data[gi*DATA_W +: DATA_W] : in_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Both are decoded from the state register, so out_ready never reaches in_ready.
  assign in_ready      = (state_reg != SKID);
  assign out_valid_int = (state_reg != EMPTY);
`else
  assign in_ready  = !out_valid_int || out_ready;
  assign load_out  = in_valid && in_ready && !flush;
  assign clear_out = flush || (out_ready && !load_out);
  assign load_data = in_data;

  // Output valid flag: set on accept, dropped on consume without reload or on flush.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid_int <= 1'b0;
    end else if (clear_out) begin
      out_valid_int <= 1'b0;
    end else if (load_out) begin
      out_valid_int <= 1'b1;
    end
  end
`endif

  // Output payload register; it holds NOP whenever the stage is empty.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_data_reg <= NOP_PAYLOAD;
    end else if (clear_out) begin
      out_data_reg <= NOP_PAYLOAD;
    end else if (load_out) begin
      out_data_reg <= load_data;
    end
  end

  // Count back-pressured cycles, sticking at all-ones; flush does not touch it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_reg <= '0;
    end else if (out_valid_int && !out_ready && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

  assign out_valid = out_valid_int;
  assign out_data  = out_data_reg;
  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg. Accepted payloads are queued as
// expected results and popped when the stage hands a payload downstream.
// A second instance, built with a 4-bit stall counter, covers saturation.
module tb_pipe_stage_reg;

  localparam int DW = 32;
  localparam int NF = 6;
  localparam int W  = DW * NF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [15:0]   stall_cnt;

  logic          s_in_valid;
  logic          s_in_ready;
  logic [W-1:0]  s_in_data;
  logic          s_flush;
  logic          s_out_valid;
  logic          s_out_ready;
  logic [W-1:0]  s_out_data;
  logic [3:0]    s_stall_cnt;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] sb[$];

  pipe_stage_reg #(.DATA_W(DW), .NUM_FIELDS(NF), .CNT_W(16)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .stall_cnt (stall_cnt)
  );

  pipe_stage_reg #(.DATA_W(DW), .NUM_FIELDS(NF), .CNT_W(4)) u_sat (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_data   (s_in_data),
    .flush     (s_flush),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_data  (s_out_data),
    .stall_cnt (s_stall_cnt)
  );

  // Payload with field0 = v and distinct values in the other fields.
  function automatic logic [W-1:0] mk(input logic [31:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int f = 0; f < NF; f++) begin
      r[f*DW +: DW] = (f == 0) ? v : (v + 32'(f) * 32'h0100_0000);
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: settle handshakes, update the scoreboard, advance past the edge.
  task automatic step();
    logic [W-1:0] exp;
    @(negedge clk);
    if (!reset || flush) begin
      sb.delete();
    end else begin
      if (!out_valid) check("nop_when_idle", out_data, '0);
      if (out_valid && out_ready) begin
        check("sb_has_expected", W'(sb.size() != 0), W'(1));
        if (sb.size() != 0) begin
          exp = sb.pop_front();
          check("out_order", out_data, exp);
        end
      end
      if (in_valid && in_ready) sb.push_back(in_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && sb.size() != 0; i++) step();
    check("drain_empty", W'(sb.size()), W'(0));
    check("drain_idle", W'(out_valid), W'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    s_in_valid = 1'b0; s_out_ready = 1'b0; s_flush = 1'b0; s_in_data = mk(32'h55);
    step();
    step();
    reset = 1'b1;
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_out_data", out_data, '0);
    check("rst_stall_cnt", W'(stall_cnt), W'(0));
    check("rst_in_ready", W'(in_ready), W'(1));
    check("rst_sat_stall_cnt", W'(s_stall_cnt), W'(0));

    // Single transfer
    in_data = mk(32'h20); in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("single_valid", W'(out_valid), W'(1));
    check("single_field0", W'(out_data[31:0]), W'(32'h20));
    step();
    check("single_after_valid", W'(out_valid), W'(0));
    check("single_after_data", out_data, '0);

    // Back-pressure for 5 cycles with a payload held
    out_ready = 1'b0; in_valid = 1'b1; in_data = mk(32'hA0);
    step();
    in_data = mk(32'hB0);
`ifdef PIPE_STAGE_SKID_EN
    check("bp_in_ready_pre", W'(in_ready), W'(1));
`else
    check("bp_in_ready_pre", W'(in_ready), W'(0));
`endif
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_data_stable", out_data, mk(32'hA0));
      check("bp_valid_stable", W'(out_valid), W'(1));
      check("bp_in_ready", W'(in_ready), W'(0));
    end
    check("bp_stall_cnt", W'(stall_cnt), W'(5));
    in_valid = 1'b0; out_ready = 1'b1;
    drain();

    // Streaming 8 back-to-back payloads
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1'b1;
      in_data = mk(32'(k));
      check("stream_in_ready", W'(in_ready), W'(1));
      step();
    end
    in_valid = 1'b0;
    check("stream_inflight", W'(sb.size()), W'(1));
    drain();
    check("stream_stall_cnt", W'(stall_cnt), W'(5));

    // Flush with FULL (and SKID when enabled) and in_valid=1
    out_ready = 1'b0; in_valid = 1'b1; in_data = mk(32'hC0);
    step();
    in_data = mk(32'hD0);
    step();
    flush = 1'b1; in_data = mk(32'hE0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_valid", W'(out_valid), W'(0));
    check("flush_data", out_data, '0);
    check("flush_stall_cnt", W'(stall_cnt), W'(7));
    out_ready = 1'b1;
    repeat (3) step();
    check("post_flush_idle", W'(out_valid), W'(0));

    // Reset priority over flush, mid-stream with stall_cnt=3
    reset = 1'b0;
    step();
    reset = 1'b1;
    out_ready = 1'b0; in_valid = 1'b1; in_data = mk(32'hF0);
    step();
    in_data = mk(32'hF1);
    repeat (3) step();
    check("prio_stall_pre", W'(stall_cnt), W'(3));
    reset = 1'b0; flush = 1'b1; out_ready = 1'b1; in_data = mk(32'hF2);
    step();
    check("prio_valid", W'(out_valid), W'(0));
    check("prio_data", out_data, '0);
    check("prio_stall_cnt", W'(stall_cnt), W'(0));
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
    check("prio_in_ready", W'(in_ready), W'(1));
    repeat (2) step();
    check("prio_nothing_emerges", W'(out_valid), W'(0));

    // Saturation with CNT_W=4
    s_in_valid = 1'b1;
    step();
    s_in_valid = 1'b0;
    check("sat_valid", W'(s_out_valid), W'(1));
    repeat (14) step();
    check("sat_cnt_14", W'(s_stall_cnt), W'(4'hE));
    step();
    check("sat_cnt_15", W'(s_stall_cnt), W'(4'hF));
    repeat (5) step();
    check("sat_cnt_20_held", W'(s_stall_cnt), W'(4'hF));
    check("sat_data_stable", s_out_data, mk(32'h55));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
